control_sequencer: RTL and testbench

//  Instruction-cycle FSM of the mini CPU, directly upstream of the fetch stage.

---
 rtl/control_sequencer.sv | 164 ++++++++++++++++
 tb/tb_control_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Instruction-cycle sequencer of the mini CPU: owns the PC, drives
// instruction-memory reads, strobes fetch/execute and handles halt.
//
// Parameters:
//   MEM_LAT    instruction-memory read latency in cycles (1..15)
//   PC_RESET   PC value loaded on reset
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   run                level: 1 = run program, 0 = stop after current instr
//   in_opcode          opcode from fetch stage (valid in DECODE)
//   in_address         address field from fetch stage (valid in DECODE)
//   acc_zero           accumulator==0 flag, sampled in DECODE
//   step_mode, step    single-step controls (only with SINGLE_STEP_EN)
//   out_pc             program counter / instruction-memory address
//   imem_rd            read strobe (FETCH)
//   fetch_ce           fetch-stage capture enable (LATCH)
//   exec_ce            one-cycle execute strobe (EXEC)
//   halted             high while in HALT
//   out_state          current FSM state, for debug
//
// Optional feature macro: SINGLE_STEP_EN adds the step ports and PAUSE.

module control_sequencer #(
    parameter int unsigned MEM_LAT  = 2,
    parameter logic [11:0] PC_RESET = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [3:0]  in_opcode,
    input  logic [11:0] in_address,
    input  logic        acc_zero,
`ifdef SINGLE_STEP_EN
    input  logic        step_mode,
    input  logic        step,
`endif
    output logic [11:0] out_pc,
    output logic        imem_rd,
    output logic        fetch_ce,
    output logic        exec_ce,
    output logic        halted,
    output logic [2:0]  out_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [2:0] S_PAUSE  = 3'd6;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

    logic [2:0]  state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [3:0]  lat_q, lat_d;
    logic [2:0]  retire_state;

    // Where to go once an instruction completes.
    always_comb begin
        retire_state = run ? S_FETCH : S_IDLE;
`ifdef SINGLE_STEP_EN
        if (run && step_mode) begin
            retire_state = S_PAUSE;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lat_d   = lat_q;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (lat_q == LAT_LAST) begin
                    lat_d   = 4'd0;
                    state_d = S_LATCH;
                end else begin
                    lat_d = lat_q + 4'd1;
                end
            end
            S_LATCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (in_opcode)
                    OP_NOP: begin
                        pc_d    = pc_q + 12'd1;
                        state_d = retire_state;
                    end
                    OP_JMP: begin
                        pc_d    = in_address;
                        state_d = retire_state;
                    end
                    OP_JZ: begin
                        pc_d    = acc_zero ? in_address : pc_q + 12'd1;
                        state_d = retire_state;
                    end
                    OP_HLT: begin
                        state_d = S_HALT;
                    end
                    default: begin
                        state_d = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                pc_d    = pc_q + 12'd1;
                state_d = retire_state;
            end
            S_HALT: begin
                if (!run) begin
                    state_d = S_IDLE;
                end
            end
`ifdef SINGLE_STEP_EN
            S_PAUSE: begin
                if (!run) begin
                    state_d = S_IDLE;
                end else if (step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            // Illegal codes (and PAUSE when single-step is absent) recover.
            default: begin
                state_d = S_IDLE;
                lat_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= PC_RESET;
            lat_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lat_q   <= lat_d;
        end
    end

    assign out_pc    = pc_q;
    assign out_state = state_q;
    assign imem_rd   = (state_q == S_FETCH);
    assign fetch_ce  = (state_q == S_LATCH);
    assign exec_ce   = (state_q == S_EXEC);
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer (MEM_LAT=2): directed
// scenarios plus randomized instruction streams against a PC model.

module tb_control_sequencer;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [3:0]  in_opcode;
    logic [11:0] in_address;
    logic        acc_zero;
    logic        step_mode;
    logic        step;
    logic [11:0] out_pc;
    logic        imem_rd;
    logic        fetch_ce;
    logic        exec_ce;
    logic        halted;
    logic [2:0]  out_state;

    int n_cmp;
    int n_bad;
    logic [11:0] ref_pc;

    control_sequencer #(.MEM_LAT(LAT), .PC_RESET(12'h000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .in_opcode  (in_opcode),
        .in_address (in_address),
        .acc_zero   (acc_zero),
`ifdef SINGLE_STEP_EN
        .step_mode  (step_mode),
        .step       (step),
`endif
        .out_pc     (out_pc),
        .imem_rd    (imem_rd),
        .fetch_ce   (fetch_ce),
        .exec_ce    (exec_ce),
        .halted     (halted),
        .out_state  (out_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_ctrl(input logic [3:0] op);
        return op == 4'h0 || op == 4'h8 || op == 4'h9 || op == 4'hF;
    endfunction

    function automatic logic [11:0] model_pc(input logic [11:0] pc,
                                             input logic [3:0] op,
                                             input logic [11:0] a,
                                             input bit az);
        int nxt;
        nxt = pc;
        if (op == 4'h8) nxt = a;
        else if (op == 4'h9) nxt = az ? a : pc + 1;
        else if (op != 4'hF) nxt = pc + 1;
        return 12'(nxt % 4096);
    endfunction

    // Bring the DUT to the start of a FETCH from wherever it rests.
    task automatic go_fetch();
        bit ok;
        ok = 0;
        for (int k = 0; k < 12; k++) begin
            if (out_state == 3'd1) begin
                ok = 1;
                break;
            end
            run  = (out_state == 3'd5) ? 1'b0 : 1'b1;
            step = 1'b1;
            @(negedge clk);
        end
        step = 1'b0;
        run  = 1'b1;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL go_fetch: state %0d, required 1", out_state);
        end
    endtask

    // Runs one instruction from the first FETCH cycle to its retire.
    task automatic exec_instr(input logic [3:0] op, input logic [11:0] a,
                              input bit az, input bit run_after);
        int cyc, n_rd, n_fc, n_ex;
        bit seen, done;
        logic [2:0] exp_st;
        int exp_cyc;
        n_cmp++;
        if (out_pc !== ref_pc) begin
            n_bad++;
            $display("FAIL pc_start: got %h, required %h", out_pc, ref_pc);
        end
        in_opcode  = op;
        in_address = a;
        acc_zero   = az;
        run        = run_after;
        cyc = 0; n_rd = 0; n_fc = 0; n_ex = 0; seen = 0; done = 0;
        for (int k = 0; k < 40; k++) begin
            if (imem_rd)  n_rd++;
            if (fetch_ce) n_fc++;
            if (exec_ce)  n_ex++;
            if (out_state == 3'd3 || out_state == 3'd4) seen = 1;
            @(negedge clk);
            cyc++;
            if (seen && out_state != 3'd3 && out_state != 3'd4) begin
                done = 1;
                break;
            end
        end
        ref_pc  = model_pc(ref_pc, op, a, az);
        exp_cyc = is_ctrl(op) ? LAT + 2 : LAT + 3;
        if (op == 4'hF) exp_st = 3'd5;
        else if (!run_after) exp_st = 3'd0;
        else if (step_mode) exp_st = 3'd6;
        else exp_st = 3'd1;
        n_cmp++;
        if (!done || cyc != exp_cyc) begin
            n_bad++;
            $display("FAIL latency op %h: got %0d, required %0d",
                     op, cyc, exp_cyc);
        end
        n_cmp++;
        if (n_rd != LAT || n_fc != 1) begin
            n_bad++;
            $display("FAIL strobes op %h: rd %0d fc %0d, required %0d 1",
                     op, n_rd, n_fc, LAT);
        end
        n_cmp++;
        if (n_ex != (is_ctrl(op) ? 0 : 1)) begin
            n_bad++;
            $display("FAIL exec_ce op %h: got %0d cycles", op, n_ex);
        end
        n_cmp++;
        if (out_pc !== ref_pc || out_state !== exp_st) begin
            n_bad++;
            $display("FAIL retire op %h: pc %h st %0d, required %h %0d",
                     op, out_pc, out_state, ref_pc, exp_st);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        run   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_pc !== 12'h000 || out_state !== 3'd0 || imem_rd !== 1'b0 ||
            fetch_ce !== 1'b0 || exec_ce !== 1'b0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: pc %h st %0d rd %b fc %b ex %b h %b",
                     out_pc, out_state, imem_rd, fetch_ce, exec_ce, halted);
        end
        rst_n = 1'b1;
        run   = 1'b0;
        ref_pc = 12'h000;
        @(negedge clk);
    endtask

    task automatic test_nop();
        go_fetch();
        exec_instr(4'h0, 12'h000, 1'b0, 1'b1);
    endtask

    task automatic test_jmp();
        go_fetch();
        exec_instr(4'h8, 12'h345, 1'b0, 1'b1);
    endtask

    task automatic test_jz();
        go_fetch();
        exec_instr(4'h8, 12'h020, 1'b0, 1'b1);
        exec_instr(4'h9, 12'h010, 1'b1, 1'b1);
        exec_instr(4'h8, 12'h020, 1'b0, 1'b1);
        exec_instr(4'h9, 12'h010, 1'b0, 1'b1);
    endtask

    task automatic test_exec_wrap();
        go_fetch();
        exec_instr(4'h8, 12'hFFF, 1'b0, 1'b1);
        exec_instr(4'h1, 12'h000, 1'b0, 1'b0);
    endtask

    task automatic test_halt();
        go_fetch();
        exec_instr(4'h8, 12'h007, 1'b0, 1'b1);
        exec_instr(4'hF, 12'h000, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (halted !== 1'b1 || imem_rd !== 1'b0 || out_pc !== 12'h007) begin
            n_bad++;
            $display("FAIL halt_hold: h %b rd %b pc %h, required 1 0 007",
                     halted, imem_rd, out_pc);
        end
        run = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_state !== 3'd0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_exit: st %0d h %b, required 0 0",
                     out_state, halted);
        end
    endtask

    task automatic test_reset_abort();
        go_fetch();
        in_opcode = 4'h3;
        for (int k = 0; k < 10 && out_state != 3'd3; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (exec_ce !== 1'b0 || out_state !== 3'd0 || out_pc !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_abort: ex %b st %0d pc %h, required 0 0 000",
                     exec_ce, out_state, out_pc);
        end
        rst_n  = 1'b1;
        ref_pc = 12'h000;
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        go_fetch();
        step_mode = 1'b1;
        exec_instr(4'h0, 12'h000, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (out_state !== 3'd6 || imem_rd !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_hold: st %0d, required 6", out_state);
        end
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        step_mode = 1'b0;
        n_cmp++;
        if (out_state !== 3'd1) begin
            n_bad++;
            $display("FAIL pause_step: st %0d, required 1", out_state);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] op;
        for (int i = 0; i < 40; i++) begin
            go_fetch();
            op = 4'($urandom_range(0, 15));
`ifdef SINGLE_STEP_EN
            step_mode = ($urandom_range(0, 4) == 0);
`endif
            exec_instr(op, 12'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0));
        end
        step_mode = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        ref_pc = 12'h000;
        rst_n = 1'b0;
        run = 1'b0;
        in_opcode = 4'h0;
        in_address = 12'h000;
        acc_zero = 1'b0;
        step_mode = 1'b0;
        step = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        test_nop();
        test_jmp();
        test_jz();
        test_exec_wrap();
        test_halt();
        test_reset_abort();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
